// File: rtl/mux_seq_nxw_pkg.sv
// Shared types and constants for the sequenced N-channel, W-bit output multiplexer.
package mux_seq_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_seq_nxw_if.sv
// Control/data bundle between a producer stage and mux_seq_nxw; the mux is the slave side.
interface mux_seq_nxw_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_in;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS-1:0]       ch_en;
    logic                      start;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      sel_err;

    modport master (
        output data_in, mode, sel, ch_en, start, out_ready,
        input  out_data, out_ch, out_valid, busy, sel_err
    );

    modport slave (
        input  data_in, mode, sel, ch_en, start, out_ready,
        output out_data, out_ch, out_valid, busy, sel_err
    );

endinterface

// File: rtl/mux_seq_nxw_comb.sv
// Purely combinational CHANNELS x WIDTH word select; out-of-range indices yield zero.
module mux_nxw_comb #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          idx,
    output logic [WIDTH-1:0]          word
);

    always_comb begin
        word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) word = data_in[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_seq_nxw.sv
// Registered N-channel mux with manual/scan sequencing behind a valid/ready output.
// Optional channel mask: define MUX_SEQ_CH_MASK_EN.
module mux_seq_nxw
    import mux_seq_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_seq_nxw_if.slave  bus
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               sel_err_q, sel_err_d;
    logic               mode_q, mode_d;
    logic               load;
    logic [SEL_W-1:0]   load_idx;
    logic [WIDTH-1:0]   mux_word;
    logic               sel_ok;
    logic               has_next;
    logic [SEL_W-1:0]   next_idx;
`ifdef MUX_SEQ_CH_MASK_EN
    logic [CHANNELS-1:0] ch_en_q, ch_en_d;
    logic                any_en;
    logic [SEL_W-1:0]    first_idx;
`endif

    mux_nxw_comb #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) u_mux (
        .data_in (bus.data_in),
        .idx     (load_idx),
        .word    (mux_word)
    );

    // Legality of the manual select and the next channel to visit in an ongoing sweep.
    always_comb begin
        sel_ok   = 1'b0;
        has_next = 1'b0;
        next_idx = idx_q;
`ifdef MUX_SEQ_CH_MASK_EN
        any_en    = 1'b0;
        first_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (bus.sel == SEL_W'(k) && bus.ch_en[k]) sel_ok = 1'b1;
            if (bus.ch_en[k]) begin
                any_en    = 1'b1;
                first_idx = SEL_W'(k);
            end
            if (ch_en_q[k] && SEL_W'(k) > idx_q) begin
                has_next = 1'b1;
                next_idx = SEL_W'(k);
            end
        end
`else
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.sel == SEL_W'(k)) sel_ok = 1'b1;
        end
        if (idx_q != LAST_CH) begin
            has_next = 1'b1;
            next_idx = idx_q + SEL_W'(1);
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        sel_err_d   = 1'b0;
        mode_d      = mode_q;
        load        = 1'b0;
        load_idx    = idx_q;
`ifdef MUX_SEQ_CH_MASK_EN
        ch_en_d     = ch_en_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_MANUAL) begin
                        if (sel_ok) begin
                            mode_d   = MODE_MANUAL;
                            load     = 1'b1;
                            load_idx = bus.sel;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end else begin
                        mode_d = MODE_SCAN;
`ifdef MUX_SEQ_CH_MASK_EN
                        ch_en_d = bus.ch_en;
                        if (any_en) begin
                            load     = 1'b1;
                            load_idx = first_idx;
                        end else begin
                            // Empty mask: spend one busy cycle with nothing to present.
                            state_d = ACTIVE;
                        end
`else
                        load     = 1'b1;
                        load_idx = '0;
`endif
                    end
                end
            end
            ACTIVE: begin
                if (!out_valid_q) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (mode_q == MODE_SCAN && has_next) begin
                        load     = 1'b1;
                        load_idx = next_idx;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            idx_d       = load_idx;
            out_valid_d = 1'b1;
            state_d     = ACTIVE;
        end
        busy_d = (state_d == ACTIVE);
    end

    always_comb begin
        out_data_d = load ? mux_word : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sel_err_q   <= 1'b0;
            mode_q      <= MODE_MANUAL;
`ifdef MUX_SEQ_CH_MASK_EN
            ch_en_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sel_err_q   <= sel_err_d;
            mode_q      <= mode_d;
`ifdef MUX_SEQ_CH_MASK_EN
            ch_en_q     <= ch_en_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sel_err   = sel_err_q;

endmodule
